// File: rtl/dtree_frame_loader.sv
// Frame loader for a combinational decision-tree classifier: collects six
// feature bytes, waits for the classifier to settle, then hands off its class.
module dtree_frame_loader #(
    parameter int FEAT_WIDTH    = 8,
    parameter int NUM_FEAT      = 6,
    parameter int CLASS_WIDTH   = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FEAT_WIDTH-1:0]  in_data,
    input  logic                   in_last,
    output logic [FEAT_WIDTH-1:0]  X0,
    output logic [FEAT_WIDTH-1:0]  X1,
    output logic [FEAT_WIDTH-1:0]  X2,
    output logic [FEAT_WIDTH-1:0]  X3,
    output logic [FEAT_WIDTH-1:0]  X4,
    output logic [FEAT_WIDTH-1:0]  X5,
    input  logic [CLASS_WIDTH-1:0] cls_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CLASS_WIDTH-1:0] out_class,
    output logic                   frame_err,
    output logic [15:0]            frame_cnt
);

    typedef enum logic [1:0] {
        LOAD,
        SETTLE,
        DELIVER,
        DISCARD
    } state_t;

    localparam logic [2:0] LAST_IDX    = 3'(NUM_FEAT - 1);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

    state_t                state;
    logic [2:0]            idx;
    logic [3:0]            settle_cnt;
    logic [FEAT_WIDTH-1:0] x [NUM_FEAT];
    logic                  hs;

    assign in_ready = (state == LOAD) || (state == DISCARD);
    assign hs       = in_valid && in_ready;

    assign X0 = x[0];
    assign X1 = x[1];
    assign X2 = x[2];
    assign X3 = x[3];
    assign X4 = x[4];
    assign X5 = x[5];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LOAD;
            idx        <= '0;
            settle_cnt <= '0;
            out_class  <= '0;
            out_valid  <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
            for (int i = 0; i < NUM_FEAT; i++) begin
                x[i] <= '0;
            end
        end else begin
            frame_err <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (hs) begin
                        for (int i = 0; i < NUM_FEAT; i++) begin
                            if (idx == 3'(i)) begin
                                x[i] <= in_data;
                            end
                        end
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (in_last) begin
                                state      <= SETTLE;
                                settle_cnt <= SETTLE_INIT;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= DISCARD;
                            end
                        end else if (in_last) begin
                            idx       <= '0;
                            frame_err <= 1'b1;
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                SETTLE: begin
                    // cls_in is sampled after SETTLE_CYCLES cycles of stable X
                    settle_cnt <= settle_cnt - 4'd1;
                    if (settle_cnt == 4'd1) begin
                        out_class <= cls_in;
                        out_valid <= 1'b1;
                        state     <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= LOAD;
                    end
                end
                DISCARD: begin
                    if (hs && in_last) begin
                        state <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule
